// File: rtl/axi_read_master.sv
// axi_read_master: single-burst AXI4 read master that fetches one aligned cache block per request and streams its beats out.
module axi_read_master #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WORDS = 16
) (
  input  logic                           clk,
  input  logic                           arstn,
  input  logic                           i_start_read,
  input  logic [ADDR_WIDTH-1:0]          i_addr,
  output logic                           o_read_last,
  output logic                           o_word_valid,
  output logic [DATA_WIDTH-1:0]          o_data_word,
  output logic [$clog2(BLOCK_WORDS)-1:0] o_word_idx,
  output logic                           o_busy,
  output logic                           o_error,
  output logic                           o_ar_valid,
  output logic [ADDR_WIDTH-1:0]          o_ar_addr,
  output logic [7:0]                     o_ar_len,
  output logic [2:0]                     o_ar_size,
  output logic [1:0]                     o_ar_burst,
  input  logic                           i_ar_ready,
  input  logic                           i_r_valid,
  input  logic [DATA_WIDTH-1:0]          i_r_data,
  input  logic [1:0]                     i_r_resp,
  input  logic                           i_r_last,
  output logic                           o_r_ready
);
  localparam int IW = $clog2(BLOCK_WORDS);
  localparam int OFF = $clog2(BLOCK_WORDS * DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] MASK = ~((ADDR_WIDTH'(1) << OFF) - ADDR_WIDTH'(1));
  localparam logic [IW:0] LAST = (IW + 1)'(BLOCK_WORDS - 1);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;
  state_t state, next;
  logic armed, hs, fin, go;
  logic [ADDR_WIDTH-1:0] addr;
  logic [IW:0] cnt;
  assign hs = i_r_valid & (state == DATA);
  assign fin = cnt == LAST;
  assign go = (state == IDLE) & i_start_read & armed;
  assign o_ar_addr = addr;
  assign o_ar_len = 8'(BLOCK_WORDS - 1);
  assign o_ar_size = 3'($clog2(DATA_WIDTH / 8));
  assign o_ar_burst = 2'b01;
  always_ff @(posedge clk)
    if (!arstn) state <= IDLE;
    else state <= next;
  always_comb begin
    o_ar_valid = state == ADDR;
    o_r_ready = state == DATA;
    o_busy = state != IDLE;
    o_read_last = state == DONE;
    next = state;
    case (state)
      IDLE:    next = go ? ADDR : IDLE;
      ADDR:    next = i_ar_ready ? DATA : ADDR;
      DATA:    next = hs && fin ? DONE : DATA;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!arstn) begin
      armed <= 1'b1;
      addr <= '0;
      cnt <= '0;
      o_data_word <= '0;
      o_word_idx <= '0;
      o_word_valid <= 1'b0;
      o_error <= 1'b0;
    end else begin
      o_word_valid <= hs;
      armed <= !i_start_read | (armed & !(hs & fin));
      if (go) begin
        addr <= i_addr & MASK;
        cnt <= '0;
        o_error <= 1'b0;
      end
      if (hs) begin
        o_data_word <= i_r_data;
        o_word_idx <= cnt[IW-1:0];
        cnt <= cnt + (IW + 1)'(1);
        if (i_r_resp != 2'b00 || i_r_last != fin) o_error <= 1'b1;
      end
    end
endmodule

// File: tb/tb_axi_read_master.sv
// tb_axi_read_master: directed-plus-random bench acting as AXI slave, checked against a block-refill reference model.
module tb_axi_read_master;
  localparam int AW = 32, DW = 32, BW = 16;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic arstn, i_start_read, i_ar_ready, i_r_valid, i_r_last;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_r_data;
  logic [1:0] i_r_resp;
  logic o_read_last, o_word_valid, o_busy, o_error, o_ar_valid, o_r_ready;
  logic [DW-1:0] o_data_word;
  logic [3:0] o_word_idx;
  logic [AW-1:0] o_ar_addr;
  logic [7:0] o_ar_len;
  logic [2:0] o_ar_size;
  logic [1:0] o_ar_burst;
  axi_read_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_WORDS(BW)) dut (
    .clk(clk), .arstn(arstn), .i_start_read(i_start_read), .i_addr(i_addr),
    .o_read_last(o_read_last), .o_word_valid(o_word_valid), .o_data_word(o_data_word),
    .o_word_idx(o_word_idx), .o_busy(o_busy), .o_error(o_error), .o_ar_valid(o_ar_valid),
    .o_ar_addr(o_ar_addr), .o_ar_len(o_ar_len), .o_ar_size(o_ar_size), .o_ar_burst(o_ar_burst),
    .i_ar_ready(i_ar_ready), .i_r_valid(i_r_valid), .i_r_data(i_r_data), .i_r_resp(i_r_resp),
    .i_r_last(i_r_last), .o_r_ready(o_r_ready)
  );
  int tests = 0, fails = 0;
  logic [DW-1:0] obs_d[$];
  int obs_i[$];
  int lasts = 0, last_idx = 0, last_wv = 0, ar_cnt = 0, wv_bad = 0, busy_cnt = 0;
  logic prev_hs = 1'b0;
  always @(negedge clk) begin
    if (o_word_valid !== prev_hs) wv_bad++;
    prev_hs = i_r_valid && o_r_ready;
    if (o_word_valid) begin
      obs_d.push_back(o_data_word);
      obs_i.push_back(int'(o_word_idx));
    end
    if (o_read_last) begin
      lasts++;
      last_idx = int'(o_word_idx);
      last_wv = int'(o_word_valid);
    end
    if (o_ar_valid && i_ar_ready) ar_cnt++;
    if (o_busy) busy_cnt++;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run_burst(input logic [AW-1:0] addr, input bit fixed, input bit throttle,
                           input int err_beat, input int lbad, input int rst_beat);
    logic [DW-1:0] d[BW];
    logic [AW-1:0] ea;
    int i, t, b0, wv0, l0, a0, bad_err;
    bit err, hs;
    ea = addr - (addr % AW'(BW * DW / 8));
    for (int k = 0; k < BW; k++) d[k] = fixed ? DW'(32'hA0 + k) : DW'($urandom);
    i_start_read = 1'b0;
    i_ar_ready = 1'b0;
    i_r_valid = 1'b0;
    @(posedge clk); #1;
    b0 = obs_d.size(); wv0 = wv_bad; l0 = lasts; a0 = ar_cnt; bad_err = 0;
    i_addr = addr;
    i_start_read = 1'b1;
    t = 0;
    while (!o_ar_valid && t < 10) begin @(posedge clk); #1; t++; end
    chk("ar_valid", 64'(o_ar_valid), 64'(1));
    if (!o_ar_valid) return;
    chk("err_clear_at_start", 64'(o_error), 64'(0));
    chk("ar_addr", 64'(o_ar_addr), 64'(ea));
    chk("ar_len_size_burst", 64'({o_ar_len, o_ar_size, o_ar_burst}), 64'({8'(BW - 1), 3'd2, 2'b01}));
    i_addr = $urandom;
    repeat (2) begin
      @(posedge clk); #1;
      chk("ar_hold", 64'({o_ar_valid, o_ar_addr}), 64'({1'b1, ea}));
    end
    i_ar_ready = 1'b1;
    @(posedge clk); #1;
    i_ar_ready = 1'b0;
    i = 0; t = 0; err = 1'b0;
    while (i < BW && t < 300) begin
      i_r_valid = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
      i_r_data = d[i];
      i_r_resp = (i == err_beat) ? 2'b10 : 2'b00;
      i_r_last = (i == lbad) ? (i != BW - 1) : (i == BW - 1);
      hs = i_r_valid && o_r_ready;
      @(posedge clk); #1;
      t++;
      if (hs) begin
        err |= (i_r_resp != 2'b00) || (i_r_last != (i == BW - 1));
        if (o_error !== err) bad_err++;
        if (i == rst_beat) begin
          arstn = 1'b0;
          i_start_read = 1'b0;
          i_r_valid = 1'b0;
          @(posedge clk); #1;
          arstn = 1'b1;
          chk("mid_reset_outputs", 64'({o_busy, o_r_ready, o_ar_valid, o_read_last, o_word_valid, o_error}), 64'(0));
          return;
        end
        i++;
      end
    end
    i_r_valid = 1'b0;
    i_r_last = 1'b0;
    i_r_resp = 2'b00;
    chk("beats_accepted", 64'(i), 64'(BW));
    repeat (3) @(posedge clk);
    #1;
    chk("word_count", 64'(obs_d.size() - b0), 64'(BW));
    for (int k = 0; k < BW; k++)
      if (b0 + k < obs_d.size()) chk("word_idx_data", {32'(obs_i[b0 + k]), obs_d[b0 + k]}, {32'(k), d[k]});
    chk("read_last_count", 64'(lasts - l0), 64'(1));
    chk("read_last_idx_wv", 64'({last_idx, last_wv}), 64'({BW - 1, 1}));
    chk("ar_count", 64'(ar_cnt - a0), 64'(1));
    chk("error_final", 64'(o_error), 64'(err));
    chk("error_timing", 64'(bad_err), 64'(0));
    chk("word_valid_gaps", 64'(wv_bad - wv0), 64'(0));
    chk("idle_after", 64'(o_busy), 64'(0));
  endtask
  initial begin
    int a, b;
    arstn = 1'b0; i_start_read = 1'b0; i_addr = '0; i_ar_ready = 1'b0;
    i_r_valid = 1'b0; i_r_data = '0; i_r_resp = 2'b00; i_r_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", 64'({o_ar_valid, o_r_ready, o_word_valid, o_read_last, o_busy, o_error}), 64'(0));
    chk("reset_data", {o_data_word, 28'(o_word_idx), 4'(0)}, 64'(0));
    chk("reset_ar_addr", 64'(o_ar_addr), 64'(0));
    arstn = 1'b1;
    run_burst(32'h0000_1234, 1'b1, 1'b0, -1, -1, -1);
    a = ar_cnt; b = busy_cnt;
    repeat (5) @(posedge clk);
    #1;
    chk("held_no_second_ar", 64'(ar_cnt - a), 64'(0));
    chk("held_stays_idle", 64'(busy_cnt - b), 64'(0));
    run_burst($urandom, 1'b0, 1'b1, -1, -1, -1);
    run_burst($urandom, 1'b0, 1'b0, 7, -1, -1);
    run_burst($urandom, 1'b0, 1'b1, -1, 3, -1);
    run_burst($urandom, 1'b0, 1'b0, -1, 15, -1);
    run_burst($urandom, 1'b0, 1'b0, -1, -1, 5);
    run_burst($urandom, 1'b0, 1'b0, -1, -1, -1);
    for (int r = 0; r < 4; r++) run_burst($urandom, 1'b0, 1'($urandom_range(0, 1)), -1, -1, -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axi_read_master.md
AXI_READ_MASTER -- requirements
Module: axi_read_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning AXI read data width in bits; legal values are 32 and 64.
REQ-003 SHALL have parameter BLOCK_WORDS, default 16, meaning beats per cache-block refill; legal values are powers of two from 2 to 256.
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 arstn  input  1  synchronous active-low reset.
REQ-007 i_start_read  input  1  level request from the cache FSMs (OR of instruction and data requests).
REQ-008 i_addr  input  ADDR_WIDTH  refill byte address, any alignment.
REQ-009 o_read_last  output  1  one-cycle pulse: block refill finished.
REQ-010 o_word_valid  output  1  o_data_word and o_word_idx carry a valid beat.
REQ-011 o_data_word  output  DATA_WIDTH  received beat.
REQ-012 o_word_idx  output  log2(BLOCK_WORDS)  beat position in the block.
REQ-013 o_busy  output  1  high in any state except IDLE.
REQ-014 o_error  output  1  sticky transaction error flag.
REQ-015 o_ar_valid, o_ar_addr (ADDR_WIDTH), o_ar_len (8), o_ar_size (3), o_ar_burst (2)  outputs  AXI4 AR channel.
REQ-016 i_ar_ready  input  1  AXI4 AR ready.
REQ-017 i_r_valid (1), i_r_data (DATA_WIDTH), i_r_resp (2), i_r_last (1)  inputs  AXI4 R channel.
REQ-018 o_r_ready  output  1  AXI4 R ready.

Function
REQ-019 SHALL implement the states IDLE, ADDR, DATA and DONE.
REQ-020 In IDLE, when i_start_read=1 and armed=1, SHALL latch i_addr with its low log2(BLOCK_WORDS*DATA_WIDTH/8) bits cleared, clear o_error, clear the beat counter, and go to ADDR.
REQ-021 armed SHALL be cleared on entry to DONE and set in any cycle where i_start_read=0, so that a held request cannot start a second burst.
REQ-022 In ADDR, SHALL drive o_ar_valid=1 with constant o_ar_addr until the cycle i_ar_ready=1, then go to DATA.
REQ-023 o_ar_len SHALL equal BLOCK_WORDS-1, o_ar_size SHALL equal log2(DATA_WIDTH/8), and o_ar_burst SHALL equal 2'b01 (INCR), constant in all states.
REQ-024 In DATA, SHALL drive o_r_ready=1; o_r_ready SHALL be 0 in all other states.
REQ-025 On each beat handshake (i_r_valid & o_r_ready), SHALL register i_r_data into o_data_word and the counter value into o_word_idx, and assert o_word_valid in the following cycle only, then increment the counter.
REQ-026 The beat counter SHALL be log2(BLOCK_WORDS)+1 bits and SHALL NOT wrap inside a burst.
REQ-027 On the handshake with counter = BLOCK_WORDS-1, SHALL go to DONE.
REQ-028 o_read_last SHALL be asserted in the DONE cycle, coincident with o_word_valid for the final beat, and DONE SHALL return to IDLE after one cycle.
REQ-029 SHALL set o_error on any handshake with i_r_resp != 2'b00.
REQ-030 SHALL set o_error when i_r_last=1 on a non-final beat or i_r_last=0 on the final beat.
REQ-031 An early i_r_last SHALL NOT end the burst; the FSM SHALL continue counting to BLOCK_WORDS beats.
REQ-032 o_error SHALL hold until the next accepted start; it SHALL NOT affect o_read_last timing.
REQ-033 Changes of i_start_read or i_addr outside IDLE SHALL be ignored.
REQ-034 i_r_valid=0 cycles in DATA SHALL stall the counter without emitting o_word_valid.

Reset
REQ-035 With arstn=0 at a rising edge, SHALL enter IDLE, set armed=1, and set the counter to 0.
REQ-036 Reset SHALL force o_ar_valid, o_r_ready, o_word_valid, o_read_last, o_busy and o_error to 0, and o_data_word, o_word_idx and the latched address to 0.
REQ-037 Reset mid-burst SHALL abandon the transaction immediately, including dropping o_ar_valid before i_ar_ready; this is the only permitted AR withdrawal.

Verification
REQ-038 Aligned refill: i_addr=0x0000_1234, start held, i_ar_ready=1 after 2 cycles, 16 back-to-back beats with data 0xA0+idx and correct i_r_last -> o_ar_addr=0x0000_1200, o_ar_len=15, o_ar_size=2, o_ar_burst=1; 16 o_word_valid pulses with idx 0..15; one o_read_last with idx 15; o_error=0.
REQ-039 Throttled R channel: i_r_valid randomly 50% low -> identical word sequence, no o_word_valid during gaps, single o_read_last.
REQ-040 Held request: i_start_read kept 1 for 5 cycles after o_read_last -> no second AR; after one low cycle then high -> second burst starts.
REQ-041 Error response: beat 7 with i_r_resp=2'b10 -> o_error=1 from the cycle after beat 7, burst completes with 16 words, o_error cleared at the next start.
REQ-042 Protocol violation: i_r_last=1 on beat 3 -> o_error=1; the FSM still collects 16 beats; o_read_last occurs once after beat 15.
REQ-043 Reset mid-burst: arstn=0 after beat 5 -> next cycle o_busy=0, o_r_ready=0, o_ar_valid=0, o_read_last=0; a new start then produces a clean burst with idx restarting at 0.
